// File: rtl/ysyx_23060208_axil_sram_if.sv
// AXI4-Lite bundle between the LSU master and the SRAM model.
// master drives AW/W/AR and B/R ready; slave drives the rest.
interface ysyx_23060208_axil_sram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid,
    output bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid,
    input  bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/ysyx_23060208_axil_sram.sv
// AXI4-Lite SRAM model: byte-strobed word array, independent
// read/write FSMs with configurable latency; clk, rst (async low), bus.
module ysyx_23060208_axil_sram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h8000_0000,
  parameter int RD_LATENCY = 1,
  parameter int WR_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  ysyx_23060208_axil_sram_if.slave bus
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFB = $clog2(NB);
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] SPAN =
    (ADDR_WIDTH+1)'(DEPTH * NB);
  localparam logic [3:0] RCNT0 = 4'(RD_LATENCY - 1);
  localparam logic [3:0] WCNT0 = 4'(WR_LATENCY - 1);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE, R_WAIT, R_RESP
  } rstate_t;

  typedef enum logic [2:0] {
    W_IDLE, W_HAVE_AW, W_HAVE_W, W_WAIT, W_RESP
  } wstate_t;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  rstate_t               r_rst;
  logic [3:0]            r_rcnt;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic                  r_arready;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  wstate_t               r_wst;
  logic [3:0]            r_wcnt;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NB-1:0]         r_wstrb;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [1:0]            r_bresp;

  logic [ADDR_WIDTH-1:0] w_roff;
  logic [ADDR_WIDTH-1:0] w_woff;
  logic                  w_rin;
  logic                  w_win;
  logic [IDXW-1:0]       w_ridx;
  logic [IDXW-1:0]       w_widx;
  logic                  w_arhs;
  logic                  w_awhs;
  logic                  w_whs;
  logic                  w_commit;

  assign w_roff = r_araddr - BASE_ADDR;
  assign w_woff = r_awaddr - BASE_ADDR;
  assign w_rin  = (r_araddr >= BASE_ADDR)
               && ({1'b0, w_roff} < SPAN);
  assign w_win  = (r_awaddr >= BASE_ADDR)
               && ({1'b0, w_woff} < SPAN);
  assign w_ridx = w_roff[OFFB +: IDXW];
  assign w_widx = w_woff[OFFB +: IDXW];

  assign w_arhs = bus.arvalid && r_arready;
  assign w_awhs = bus.awvalid && r_awready;
  assign w_whs  = bus.wvalid && r_wready;

  // Out-of-range writes still complete, they just never reach the array.
  assign w_commit = (r_wst == W_WAIT)
                 && (r_wcnt == '0) && w_win;

  assign bus.arready = r_arready;
  assign bus.rvalid  = r_rvalid;
  assign bus.rdata   = r_rdata;
  assign bus.rresp   = r_rresp;
  assign bus.awready = r_awready;
  assign bus.wready  = r_wready;
  assign bus.bvalid  = r_bvalid;
  assign bus.bresp   = r_bresp;

  // Array is not reset; a same-edge read sees the pre-commit word.
  always_ff @(posedge clk) begin
    if (w_commit) begin
      for (int i = 0; i < NB; i++) begin
        if (r_wstrb[i]) begin
          r_mem[w_widx][i*8 +: 8] <= r_wdata[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rst     <= R_IDLE;
      r_rcnt    <= '0;
      r_araddr  <= '0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= OKAY;
    end else begin
      unique case (r_rst)
        R_IDLE: begin
          r_arready <= 1'b1;
          if (w_arhs) begin
            r_araddr  <= bus.araddr;
            r_rcnt    <= RCNT0;
            r_arready <= 1'b0;
            r_rst     <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_rcnt == '0) begin
            r_rdata  <= w_rin ? r_mem[w_ridx] : '0;
            r_rresp  <= w_rin ? OKAY : SLVERR;
            r_rvalid <= 1'b1;
            r_rst    <= R_RESP;
          end else begin
            r_rcnt <= r_rcnt - 4'd1;
          end
        end
        R_RESP: begin
          if (bus.rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rst     <= R_IDLE;
          end
        end
        default: r_rst <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wst     <= W_IDLE;
      r_wcnt    <= '0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
    end else begin
      unique case (r_wst)
        W_IDLE: begin
          r_awready <= 1'b1;
          r_wready  <= 1'b1;
          if (w_awhs) r_awaddr <= bus.awaddr;
          if (w_whs) begin
            r_wdata <= bus.wdata;
            r_wstrb <= bus.wstrb;
          end
          if (w_awhs && w_whs) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_wcnt    <= WCNT0;
            r_wst     <= W_WAIT;
          end else if (w_awhs) begin
            r_awready <= 1'b0;
            r_wst     <= W_HAVE_AW;
          end else if (w_whs) begin
            r_wready <= 1'b0;
            r_wst    <= W_HAVE_W;
          end
        end
        W_HAVE_AW: begin
          if (w_whs) begin
            r_wdata  <= bus.wdata;
            r_wstrb  <= bus.wstrb;
            r_wready <= 1'b0;
            r_wcnt   <= WCNT0;
            r_wst    <= W_WAIT;
          end
        end
        W_HAVE_W: begin
          if (w_awhs) begin
            r_awaddr  <= bus.awaddr;
            r_awready <= 1'b0;
            r_wcnt    <= WCNT0;
            r_wst     <= W_WAIT;
          end
        end
        W_WAIT: begin
          if (r_wcnt == '0) begin
            r_bresp  <= w_win ? OKAY : SLVERR;
            r_bvalid <= 1'b1;
            r_wst    <= W_RESP;
          end else begin
            r_wcnt <= r_wcnt - 4'd1;
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wst     <= W_IDLE;
          end
        end
        default: r_wst <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_23060208_axil_sram.sv
// Randomised self-checking bench for the AXI4-Lite SRAM model,
// compared against a flat word-array reference of the memory map.
module tb_ysyx_23060208_axil_sram;
  localparam int RDL   = 3;
  localparam int WRL   = 2;
  localparam int DEPTH = 1024;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk;
  logic rst;
  int n_chk;
  int n_err;
  logic [31:0] mdl [DEPTH];

  ysyx_23060208_axil_sram_if #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) bus ();

  ysyx_23060208_axil_sram #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEPTH),
    .BASE_ADDR(BASE), .RD_LATENCY(RDL), .WR_LATENCY(WRL)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(DEPTH * 4));
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic int slot_idx(input int s);
    return (s == 16) ? DEPTH - 1 : s;
  endfunction

  function automatic logic [31:0] rnd_oob();
    case ($urandom_range(0, 3))
      0: return 32'h7FFF_FFFC;
      1: return 32'h8000_1000;
      2: return 32'h8000_1000 + 4 * $urandom_range(0, 255);
      default: return $urandom_range(0, 32'h7FFF_FFF0);
    endcase
  endfunction

  function automatic logic [1:0] exp_resp(input logic [31:0] a);
    return in_rng(a) ? 2'b00 : 2'b10;
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    return in_rng(a) ? mdl[widx(a)] : 32'h0;
  endfunction

  function automatic void mdl_wr(input logic [31:0] a,
                                 input logic [31:0] d,
                                 input logic [3:0] s);
    if (in_rng(a)) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) mdl[widx(a)][b*8 +: 8] = d[b*8 +: 8];
      end
    end
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s, input int awd,
                    input int wd, input int bd,
                    output logic [1:0] resp);
    bit awdn, wdn, awhs, whs;
    int c, lat;
    awdn = 0;
    wdn = 0;
    c = 0;
    bus.awaddr = a;
    bus.wdata = d;
    bus.wstrb = s;
    while (!(awdn && wdn) && c < 40) begin
      bus.awvalid = !awdn && (c >= awd);
      bus.wvalid = !wdn && (c >= wd);
      awhs = bus.awvalid && bus.awready;
      whs = bus.wvalid && bus.wready;
      @(posedge clk); #1;
      c++;
      awdn |= awhs;
      wdn |= whs;
      bus.awvalid = 1'b0;
      bus.wvalid = 1'b0;
      if (awhs) bus.awaddr = $urandom;
      if (whs) begin
        bus.wdata = $urandom;
        bus.wstrb = 4'($urandom);
      end
      chk("w_rdy", {bus.awready, bus.wready}, {!awdn, !wdn});
    end
    chk("w_hs_done", {awdn, wdn}, 2'b11);
    lat = 0;
    while (!bus.bvalid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("w_lat", lat, WRL);
    resp = bus.bresp;
    for (int i = 0; i < bd; i++) begin
      @(posedge clk); #1;
      chk("b_hold", {bus.bvalid, bus.bresp}, {1'b1, resp});
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    bus.bready = 1'b0;
    chk("b_done", {bus.bvalid, bus.awready, bus.wready}, 3'b011);
  endtask

  task automatic rd(input logic [31:0] a, input int ard,
                    input int rh, output logic [31:0] d,
                    output logic [1:0] resp);
    bit done, hs;
    int c, lat;
    done = 0;
    c = 0;
    bus.araddr = a;
    while (!done && c < 40) begin
      bus.arvalid = (c >= ard);
      hs = bus.arvalid && bus.arready;
      @(posedge clk); #1;
      c++;
      done |= hs;
    end
    bus.arvalid = 1'b0;
    bus.araddr = $urandom;
    chk("ar_done", done, 1);
    lat = 0;
    while (!bus.rvalid && lat < 40) begin
      chk("ar_low_wait", bus.arready, 0);
      @(posedge clk); #1;
      lat++;
    end
    chk("r_lat", lat, RDL);
    d = bus.rdata;
    resp = bus.rresp;
    for (int i = 0; i < rh; i++) begin
      @(posedge clk); #1;
      chk("r_hold", {bus.rvalid, bus.rdata, bus.rresp},
          {1'b1, d, resp});
      chk("ar_low_hold", bus.arready, 0);
    end
    bus.rready = 1'b1;
    @(posedge clk); #1;
    bus.rready = 1'b0;
    chk("r_done", {bus.rvalid, bus.arready}, 2'b01);
  endtask

  task automatic do_wr(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input int awd,
                       input int wd, input int bd);
    logic [1:0] r;
    wr(a, d, s, awd, wd, bd, r);
    chk("bresp", r, exp_resp(a));
    mdl_wr(a, d, s);
  endtask

  task automatic do_rd(input logic [31:0] a, input int ard,
                       input int rh);
    logic [31:0] d;
    logic [1:0] r;
    rd(a, ard, rh, d, r);
    chk("rdata", d, exp_data(a));
    chk("rresp", r, exp_resp(a));
  endtask

  initial begin
    logic [31:0] d, ed, wa, ra;
    logic [1:0] rr, br;
    logic [3:0] ws;
    bit seen;
    int ri, wi;
    n_chk = 0;
    n_err = 0;
    rst = 1'b0;
    bus.awaddr = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {bus.arready, bus.awready, bus.wready,
                    bus.rvalid, bus.bvalid}, 5'b0);
    chk("rst_dat", {bus.rdata, bus.rresp, bus.bresp}, 36'h0);
    rst = 1'b1;
    #1;
    @(posedge clk); #1;
    chk("rel_rdy", {bus.arready, bus.awready, bus.wready}, 3'b111);

    for (int s = 0; s <= 16; s++) begin
      do_wr(BASE + 32'(slot_idx(s) * 4), $urandom, 4'hF,
            $urandom_range(0, 2), $urandom_range(0, 2), 0);
    end

    do_wr(32'h8000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    do_rd(32'h8000_0004, 0, 0);
    do_wr(32'h8000_0008, 32'h1122_3344, 4'hF, 0, 0, 1);
    do_wr(32'h8000_0008, 32'h0000_AA00, 4'h2, 1, 0, 0);
    rd(32'h8000_0008, 0, 0, d, rr);
    chk("strobe_merge", d, 32'h1122_AA44);
    do_wr(32'h8000_000C, 32'h5566_7788, 4'hF, 3, 0, 0);
    do_rd(32'h8000_000C, 0, 0);
    do_wr(32'h8000_0010, 32'hCAFE_F00D, 4'hF, 0, 2, 0);
    do_wr(32'h7FFF_FFFC, 32'h0BAD_0BAD, 4'hF, 0, 0, 0);
    do_rd(32'h8000_0000, 1, 0);
    rd(32'h8000_1000, 0, 0, d, rr);
    chk("oob_rdata", d, 0);
    chk("oob_rresp", rr, 2'b10);
    do_wr(32'h8000_1000, 32'h0BAD_0BAD, 4'hF, 1, 1, 0);
    do_wr(32'h8000_0004, 32'hFFFF_FFFF, 4'h0, 0, 0, 0);
    do_rd(32'h8000_0004, 0, 1);
    do_wr(32'h8000_0FFF, 32'h1357_9BDF, 4'hF, 0, 0, 0);
    do_rd(32'h8000_0FFC, 0, 0);

    ed = exp_data(32'h8000_0004);
    fork
      rd(32'h8000_0004, 0, 5, d, rr);
      wr(32'h8000_0014, 32'h2468_ACE0, 4'hF, 5, 5, 0, br);
    join
    chk("bp_rdata", d, ed);
    chk("bp_bresp", br, 2'b00);
    mdl_wr(32'h8000_0014, 32'h2468_ACE0, 4'hF);
    do_rd(32'h8000_0014, 0, 0);

    ed = exp_data(32'h8000_0018);
    fork
      rd(32'h8000_0018, 0, 0, d, rr);
      wr(32'h8000_0018, 32'h7777_0001, 4'hF, 1, 1, 0, br);
    join
    chk("coll_same_edge", d, ed);
    mdl_wr(32'h8000_0018, 32'h7777_0001, 4'hF);
    fork
      rd(32'h8000_0018, 0, 0, d, rr);
      wr(32'h8000_0018, 32'h7777_0002, 4'hF, 0, 0, 0, br);
    join
    mdl_wr(32'h8000_0018, 32'h7777_0002, 4'hF);
    chk("coll_prev_edge", d, 32'h7777_0002);

    for (int it = 0; it < 80; it++) begin
      ri = $urandom_range(0, 16);
      wi = (ri + $urandom_range(1, 16)) % 17;
      ra = BASE + 32'(slot_idx(ri) * 4) + $urandom_range(0, 3);
      wa = BASE + 32'(slot_idx(wi) * 4) + $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) ra = rnd_oob();
      if ($urandom_range(0, 7) == 0) wa = rnd_oob();
      ws = 4'($urandom);
      ed = $urandom;
      fork
        rd(ra, $urandom_range(0, 3), $urandom_range(0, 3), d, rr);
        wr(wa, ed, ws, $urandom_range(0, 4),
           $urandom_range(0, 4), $urandom_range(0, 3), br);
      join
      chk("rnd_rdata", d, exp_data(ra));
      chk("rnd_rresp", rr, exp_resp(ra));
      chk("rnd_bresp", br, exp_resp(wa));
      mdl_wr(wa, ed, ws);
    end
    for (int s = 0; s <= 16; s++) begin
      do_rd(BASE + 32'(slot_idx(s) * 4), 0, 0);
    end

    bus.araddr = 32'h8000_0004;
    bus.arvalid = 1'b1;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    repeat (RDL) @(posedge clk);
    #1;
    chk("pre_rst_rvalid", bus.rvalid, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_ctl", {bus.rvalid, bus.arready, bus.awready,
                     bus.wready, bus.bvalid}, 5'b0);
    chk("arst_dat", {bus.rdata, bus.rresp}, 34'h0);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("rel2_pre", {bus.arready, bus.awready, bus.wready}, 3'b000);
    @(posedge clk); #1;
    chk("rel2_rdy", {bus.arready, bus.awready, bus.wready}, 3'b111);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      seen |= bus.rvalid;
      @(posedge clk); #1;
    end
    chk("no_stale_rvalid", seen, 0);
    do_rd(32'h8000_0004, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
